// File: rtl/acc_issue_ctrl.sv
// Issue/writeback stage: owns the accumulator, issues {op, imm} to execution units
// and writes the unit result back. Optional retired-instruction counter: ACC_ISSUE_RETIRE_CNT_EN.
module acc_issue_ctrl #(
  parameter int unsigned TIMEOUT   = 8,
  parameter int unsigned DRAIN_MAX = 8,
  parameter logic [3:0]  OP_LDI    = 4'b0001
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       instr_valid,
  output logic       instr_ready,
  input  logic [3:0] instr_op,
  input  logic [7:0] instr_imm,
  output logic [3:0] ctr1,
  output logic [7:0] data1,
  output logic [7:0] data2,
  input  logic [7:0] res_in,
  input  logic       res_ctr,
  output logic [7:0] acc,
  output logic       busy,
  output logic       err
`ifdef ACC_ISSUE_RETIRE_CNT_EN
  , output logic [15:0] retired
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DRAIN} state_t;

  state_t      state_q;
  logic [15:0] cnt_q;
  logic [7:0]  acc_q;
  logic [7:0]  data2_q;
  logic [3:0]  ctr1_q;
  logic        err_q;
  logic        ready_q;
  logic        busy_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      data2_q <= '0;
      ctr1_q  <= '0;
      err_q   <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      err_q  <= 1'b0;
      ctr1_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (instr_valid && ready_q) begin
            if (instr_op == OP_LDI) begin
              acc_q <= instr_imm;
            end else if (instr_op != 4'b0000) begin
              // ctr1_q doubles as the opcode latch; it is only driven during ISSUE
              ctr1_q  <= instr_op;
              data2_q <= instr_imm;
              state_q <= S_ISSUE;
              ready_q <= 1'b0;
              busy_q  <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          state_q <= S_WAIT;
          cnt_q   <= '0;
        end
        S_WAIT: begin
          if (res_ctr) begin
            acc_q   <= res_in;
            state_q <= S_DRAIN;
            cnt_q   <= '0;
          end else if (cnt_q == 16'(TIMEOUT - 1)) begin
            err_q   <= 1'b1;
            state_q <= S_IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        S_DRAIN: begin
          if (!res_ctr) begin
            state_q <= S_IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else if (cnt_q == 16'(DRAIN_MAX - 1)) begin
            err_q   <= 1'b1;
            state_q <= S_IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign instr_ready = ready_q;
  assign busy        = busy_q;
  assign err         = err_q;
  assign ctr1        = ctr1_q;
  assign acc         = acc_q;
  assign data1       = acc_q;
  assign data2       = data2_q;

`ifdef ACC_ISSUE_RETIRE_CNT_EN
  logic        retire;
  logic [15:0] retired_q;

  // NOP and LDI retire on acceptance; unit ops retire on WAIT capture
  assign retire = ((state_q == S_IDLE) && instr_valid && ready_q &&
                   ((instr_op == 4'b0000) || (instr_op == OP_LDI))) ||
                  ((state_q == S_WAIT) && res_ctr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) retired_q <= '0;
    else if (retire) retired_q <= retired_q + 16'd1;
  end

  assign retired = retired_q;
`endif

endmodule

// File: tb/tb_acc_issue_ctrl.sv
// Directed bench for acc_issue_ctrl with a behavioural AND unit (ctr high 4 cycles).
module tb_acc_issue_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       instr_valid;
  logic       instr_ready;
  logic [3:0] instr_op;
  logic [7:0] instr_imm;
  logic [3:0] ctr1;
  logic [7:0] data1;
  logic [7:0] data2;
  logic [7:0] res_in;
  logic       res_ctr;
  logic [7:0] acc;
  logic       busy;
  logic       err;
`ifdef ACC_ISSUE_RETIRE_CNT_EN
  logic [15:0] retired;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  acc_issue_ctrl #(.TIMEOUT(8), .DRAIN_MAX(8), .OP_LDI(4'b0001)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_imm(instr_imm),
    .ctr1(ctr1), .data1(data1), .data2(data2),
    .res_in(res_in), .res_ctr(res_ctr),
    .acc(acc), .busy(busy), .err(err)
`ifdef ACC_ISSUE_RETIRE_CNT_EN
    , .retired(retired)
`endif
  );

  // AND unit model: samples ctr1, raises ctr one cycle later for 4 cycles.
  // Only the first ctr cycle carries the real result, so a second writeback shows up as 55.
  logic        unit_en = 1'b0;
  logic        extra = 1'b0;
  logic        unit_ctr = 1'b0;
  logic        armed = 1'b0;
  logic [7:0]  unit_res = 8'h00;
  logic [7:0]  res_lat = 8'h00;
  int unsigned unit_hold = 0;

  always @(posedge clk) begin
    if (armed) begin
      unit_ctr  <= 1'b1;
      unit_res  <= res_lat;
      unit_hold <= 3;
      armed     <= 1'b0;
    end else if (unit_hold != 0) begin
      unit_hold <= unit_hold - 1;
      unit_res  <= 8'h55;
    end else begin
      unit_ctr <= 1'b0;
    end
    if (unit_en && ctr1 == 4'b1110) begin
      armed   <= 1'b1;
      res_lat <= data1 & data2;
    end
  end

  assign res_ctr = unit_ctr | extra;
  assign res_in  = extra ? 8'h99 : unit_res;

  int ctr1_cycles = 0;
  always @(negedge clk) if (ctr1 != 4'b0000) ctr1_cycles++;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       valid;
    logic       pulse;
    logic [3:0] op;
    logic [7:0] imm;
    logic [7:0] exp_acc;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b1, 1'b0, 4'b0000, 8'h00, 8'h00};
    vecs[1] = '{1'b1, 1'b0, 4'b0001, 8'hF0, 8'hF0};
    vecs[2] = '{1'b1, 1'b0, 4'b0000, 8'hAA, 8'hF0};
    vecs[3] = '{1'b0, 1'b1, 4'b0000, 8'h00, 8'hF0};
    vecs[4] = '{1'b1, 1'b0, 4'b0001, 8'h5A, 8'h5A};
    vecs[5] = '{1'b0, 1'b0, 4'b0001, 8'h11, 8'h5A};
    vecs[6] = '{1'b1, 1'b0, 4'b0001, 8'hF0, 8'hF0};

    rst = 1'b1; instr_valid = 1'b0; instr_op = 4'b0000; instr_imm = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    #1;
    chk("rst_acc", acc, 8'h00);
    chk("rst_ctr1", ctr1, 4'b0000);
    chk("rst_ready", instr_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_data2", data2, 8'h00);

    // single-cycle instructions, idle res_ctr pulse, and valid low
    ctr1_cycles = 0;
    for (int unsigned i = 0; i < 7; i++) begin
      @(negedge clk);
      instr_valid = vecs[i].valid; extra = vecs[i].pulse;
      instr_op = vecs[i].op; instr_imm = vecs[i].imm;
      @(posedge clk); #1;
      instr_valid = 1'b0; extra = 1'b0;
      @(negedge clk);
      chk($sformatf("vec%0d_acc", i), acc, vecs[i].exp_acc);
      chk($sformatf("vec%0d_busy", i), busy, 1'b0);
      chk($sformatf("vec%0d_ready", i), instr_ready, 1'b1);
    end
    chk("ldi_ctr1_quiet", 16'(ctr1_cycles), 16'd0);

    // AND F0 & 3C with a 4-cycle ctr unit
    unit_en = 1'b1;
    ctr1_cycles = 0;
    @(negedge clk);
    instr_valid = 1'b1; instr_op = 4'b1110; instr_imm = 8'h3C;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    chk("and_ctr1", ctr1, 4'b1110);
    chk("and_data2", data2, 8'h3C);
    chk("and_data1", data1, 8'hF0);
    chk("and_busy", busy, 1'b1);
    chk("and_ready", instr_ready, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      chk($sformatf("and_k%0d_acc", k), acc, (k >= 3) ? 8'h30 : 8'hF0);
      chk($sformatf("and_k%0d_ready", k), instr_ready, (k >= 7) ? 1'b1 : 1'b0);
    end
    chk("and_ctr1_once", 16'(ctr1_cycles), 16'd1);

    // back-to-back with instr_valid held high
    @(negedge clk) rst = 1'b1;
    #2 rst = 1'b0;
    ctr1_cycles = 0;
    instr_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      int n;
      logic [3:0] op;
      logic [7:0] imm, ea;
      op  = (i == 0) ? 4'b0000 : (i == 1) ? 4'b0001 : 4'b1110;
      imm = (i == 0) ? 8'h00 : (i == 1) ? 8'h0F : 8'hFF;
      ea  = (i == 0) ? 8'h00 : 8'h0F;
      instr_op = op; instr_imm = imm;
      n = 0;
      while (!instr_ready && n < 50) begin @(posedge clk); #1; n++; end
      chk($sformatf("b2b%0d_wait", i), 16'(n < 50), 16'd1);
      chk($sformatf("b2b%0d_notbusy", i), busy, 1'b0);
      @(posedge clk); #1;
      if (i == 2) begin
        instr_valid = 1'b0;
        n = 0;
        while (!instr_ready && n < 50) begin @(posedge clk); #1; n++; end
        chk("b2b_and_done", 16'(n < 50), 16'd1);
      end
      chk($sformatf("b2b%0d_acc", i), acc, ea);
    end
    chk("b2b_ctr1_once", 16'(ctr1_cycles), 16'd1);
`ifdef ACC_ISSUE_RETIRE_CNT_EN
    chk("b2b_retired", retired, 16'd3);
`endif

    // timeout: unit disabled, res_ctr stays 0
    unit_en = 1'b0;
    @(negedge clk);
    instr_valid = 1'b1; instr_op = 4'b1110; instr_imm = 8'h77;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      @(posedge clk); #1;
      chk($sformatf("to_k%0d_err", k), err, (k == 9) ? 1'b1 : 1'b0);
      if (k == 8) chk("to_ready_before", instr_ready, 1'b0);
      if (k == 9) chk("to_acc", acc, 8'h0F);
      if (k == 10) chk("to_ready_after", instr_ready, 1'b1);
    end
`ifdef ACC_ISSUE_RETIRE_CNT_EN
    chk("to_retired", retired, 16'd3);
`endif

    // asynchronous reset mid-WAIT
    @(negedge clk);
    instr_valid = 1'b1; instr_op = 4'b1110; instr_imm = 8'h12;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_acc", acc, 8'h00);
    chk("arst_ctr1", ctr1, 4'b0000);
    chk("arst_ready", instr_ready, 1'b1);
    chk("arst_busy", busy, 1'b0);
    chk("arst_err", err, 1'b0);
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (err) chk("arst_no_err", err, 1'b0);
    end
    chk("arst_idle", instr_ready, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
